// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared encodings and helpers for the memory bus arbiter
package bus_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Index width that stays legal for a single-master build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// rtl/bus_arb_pick.sv - combinational priority picker, fixed or rotating start
module bus_arb_pick
  import bus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic          mode,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   base;
    int   j;
    logic found;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    base  = (mode == ARB_RR) ? int'(start) : 0;
    for (int i = 0; i < N; i++) begin
      j = base + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// rtl/bus_arb.sv - registered N-master arbiter for the CPU memory bus
// with lock support, per-transaction ack and OR-combined slave read data.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 2,
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int MODE   = 0
) (
  input  logic                clk,
  input  logic                nres,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_lock,
  input  logic [NUM_M*AW-1:0] m_a,
  input  logic [NUM_M-1:0]    m_r_nw,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0]    m_gnt,
  output logic [NUM_M-1:0]    m_ack,
  output logic [DW-1:0]       m_din,
  output logic [AW-1:0]       s_a,
  output logic                s_r_nw,
  output logic [DW-1:0]       s_dout,
  input  logic [NUM_S*DW-1:0] s_din
);

  localparam int   IW       = idx_w(NUM_M);
  localparam logic ARB_MODE = (MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [1:0]       state;
  logic [1:0]       lat_cnt;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last_owner;
  logic [IW-1:0]    next_start;
  logic [IW-1:0]    pick_idx;
  logic [NUM_M-1:0] pick_win;
  logic [NUM_M-1:0] elig;
  logic [NUM_M-1:0] owner_oh;
  logic             lock_valid;
  logic             lock_hold;
  logic             txn_rd;
  logic [DW-1:0]    rd_or;

  assign owner_oh   = NUM_M'(1) << owner;
  assign lock_hold  = lock_valid && m_lock[owner];
  // A held lock narrows arbitration to the owner alone.
  assign elig       = lock_hold ? (m_req & owner_oh) : m_req;
  assign next_start = (last_owner == IW'(NUM_M - 1)) ? '0 : last_owner + 1'b1;

  always_comb begin
    rd_or = '0;
    for (int i = 0; i < NUM_S; i++) rd_or = rd_or | s_din[i*DW +: DW];
  end

  bus_arb_pick #(
    .N  (NUM_M),
    .IW (IW)
  ) u_pick (
    .req   (elig),
    .start (next_start),
    .mode  (ARB_MODE),
    .win   (pick_win),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      owner      <= '0;
      last_owner <= IW'(NUM_M - 1);
      lock_valid <= 1'b0;
      txn_rd     <= 1'b1;
      m_gnt      <= '0;
      m_ack      <= '0;
      m_din      <= '0;
      s_a        <= '0;
      s_r_nw     <= 1'b1;
      s_dout     <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        S_IDLE: begin
          if (lock_valid && !m_lock[owner]) lock_valid <= 1'b0;
          if (|pick_win) begin
            m_gnt      <= pick_win;
            owner      <= pick_idx;
            last_owner <= pick_idx;
            s_a        <= m_a[int'(pick_idx)*AW +: AW];
            s_r_nw     <= m_r_nw[pick_idx];
            s_dout     <= m_r_nw[pick_idx] ? '0 : m_dout[int'(pick_idx)*DW +: DW];
            txn_rd     <= m_r_nw[pick_idx];
            lat_cnt    <= 2'(RD_LAT);
            state      <= S_BUSY;
          end else if (!lock_hold) begin
            m_gnt <= '0;
          end
        end
        S_BUSY: begin
          // Writes finish in their single strobe cycle; reads wait out the latency.
          if (!txn_rd || lat_cnt == 2'd0) begin
            if (txn_rd) m_din <= rd_or;
            m_ack  <= owner_oh;
            s_a    <= '0;
            s_r_nw <= 1'b1;
            s_dout <= '0;
            state  <= S_ACK;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_ACK: begin
          lock_valid <= m_lock[owner];
          if (!m_lock[owner]) m_gnt <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
